// File: rtl/cache_burst_ctrl_pkg.sv
// Shared cvw types for the cache line burst controller:
// burst FSM states and cache request encodings.
package cvw;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    DONE
  } busState_t;

  localparam logic [1:0] BUSRW_FETCH     = 2'b10;
  localparam logic [1:0] BUSRW_WRITEBACK = 2'b01;

endpackage

// File: rtl/cache_burst_ctrl_beatcounter.sv
// Beat index counter for a cache line burst.
// Synchronous clear wins over enable; last flags the final beat.
module beatcounter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (clr)     count <= '0;
    else if (en) count <= count + 1'b1;
  end

  assign last = &count;

endmodule

// File: rtl/cache_burst_ctrl.sv
// Cache line burst controller: writeback and/or fetch of one line.
// Define CACHE_BURST_BUSERR_EN to add BusErr / CacheBusErr.
module cache_burst_ctrl
  import cvw::*;
#(
  parameter int PA_BITS = 56,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  localparam int BEATSPERLINE = LINELEN / BEATLEN,
  localparam int LOGBWPL = $clog2(BEATSPERLINE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [LINELEN-1:0] ReadDataLine,
  input  logic               FlushStage,
  output logic               CacheBusAck,
  output logic               SelBusBeat,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusWData,
  input  logic [BEATLEN-1:0] BusRData,
`ifdef CACHE_BURST_BUSERR_EN
  input  logic               BusErr,
  output logic               CacheBusErr,
`endif
  input  logic               BusReady
);

  localparam int BYTESHIFT = $clog2(BEATLEN / 8);

  busState_t state, nextState;
  logic [PA_BITS-1:0] adrLatch;
  logic fetchFlag, wbFlag;
  logic busy, lastBeat, errEnd;
  logic beatEn, beatClr, start;

  assign busy  = (state == WRITEBACK) || (state == FETCH);
  assign start = (state == IDLE) && (nextState != IDLE);

`ifdef CACHE_BURST_BUSERR_EN
  logic errSeen;

  assign errEnd = busy && BusReady && BusErr;

  always_ff @(posedge clk) begin
    if (!reset)                errSeen <= 1'b0;
    else if (errEnd)           errSeen <= 1'b1;
    else if (state == IDLE)    errSeen <= 1'b0;
  end

  assign CacheBusErr = (state == DONE) && errSeen;
`else
  assign errEnd = 1'b0;
`endif

  // an errored beat ends the burst, so restart the index at zero
  assign beatEn  = busy && BusReady;
  assign beatClr = !reset || !busy || errEnd;

  beatcounter #(.W(LOGBWPL)) u_beatcounter (
    .clk   (clk),
    .clr   (beatClr),
    .en    (beatEn),
    .count (BeatCount),
    .last  (lastBeat)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:
        if (CacheBusRW != 2'b00 && !FlushStage)
          nextState = |(CacheBusRW & BUSRW_WRITEBACK) ? WRITEBACK : FETCH;
      WRITEBACK:
        if (errEnd)
          nextState = DONE;
        else if (BusReady && lastBeat)
          nextState = fetchFlag ? FETCH : DONE;
      FETCH:
        if (errEnd || (BusReady && lastBeat))
          nextState = DONE;
      DONE:
        nextState = IDLE;
      default:
        nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      adrLatch    <= '0;
      fetchFlag   <= 1'b0;
      wbFlag      <= 1'b0;
      FetchBuffer <= '0;
    end else begin
      if (start) begin
        adrLatch  <= CacheBusAdr;
        fetchFlag <= |(CacheBusRW & BUSRW_FETCH);
        wbFlag    <= |(CacheBusRW & BUSRW_WRITEBACK);
      end
      if (state == FETCH && BusReady && !errEnd)
        FetchBuffer[BeatCount*BEATLEN +: BEATLEN] <= BusRData;
    end
  end

  assign BusReq      = busy;
  assign SelBusBeat  = busy;
  assign BusWrite    = (state == WRITEBACK) && wbFlag;
  assign CacheBusAck = (state == DONE);
  assign BusAdr      = adrLatch + (PA_BITS'(BeatCount) << BYTESHIFT);
  assign BusWData    = BusWrite ? ReadDataLine[BeatCount*BEATLEN +: BEATLEN]
                                : '0;

endmodule

// File: doc/cache_burst_ctrl.md
CACHE_BURST_CTRL -- requirements
Module: cache_burst_ctrl

Interface
REQ-001 SHALL have parameter PA_BITS, default 56, physical address width.
REQ-002 SHALL have parameter LINELEN, default 512, cache line bits.
REQ-003 SHALL have parameter BEATLEN, default 64, bus beat bits; BEATSPERLINE = LINELEN/BEATLEN (power of two, at least 2); LOGBWPL = log2(BEATSPERLINE).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-006 SHALL have port CacheBusRW, input, 2, cache request: [1] line fetch, [0] line writeback.
REQ-007 SHALL have port CacheBusAdr, input, PA_BITS, line-aligned address from the cache.
REQ-008 SHALL have port ReadDataLine, input, LINELEN, victim line, stable during writeback.
REQ-009 SHALL have port FlushStage, input, 1, pipeline flush.
REQ-010 SHALL have port CacheBusAck, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port SelBusBeat, output, 1, high while a burst is in flight.
REQ-012 SHALL have port BeatCount, output, LOGBWPL, current beat index.
REQ-013 SHALL have port FetchBuffer, output, LINELEN, assembled fetched line.
REQ-014 SHALL have ports BusReq (output, 1), BusWrite (output, 1), BusAdr (output, PA_BITS), BusWData (output, BEATLEN), BusRData (input, BEATLEN) and BusReady (input, 1; beat accepted or returned this cycle).

Function
REQ-015 SHALL implement FSM states IDLE, WRITEBACK, FETCH and DONE.
REQ-016 IDLE: CacheBusRW != 00 and FlushStage=0 SHALL go to WRITEBACK if [0]=1, else to FETCH; FlushStage=1 SHALL block the start.
REQ-017 CacheBusRW=11 SHALL perform writeback then fetch, with one ack after the fetch.
REQ-018 BusReq SHALL be high in WRITEBACK and FETCH only; BusWrite SHALL equal (state==WRITEBACK).
REQ-019 BusAdr SHALL equal the latched CacheBusAdr + BeatCount*(BEATLEN/8), with the sum truncated to PA_BITS.
REQ-020 CacheBusAdr, the fetch flag and the writeback flag SHALL be latched on leaving IDLE; later input changes SHALL be ignored until IDLE.
REQ-021 BusWData SHALL equal ReadDataLine[BeatCount*BEATLEN +: BEATLEN].
REQ-022 In FETCH with BusReady=1, BusRData SHALL be written to FetchBuffer[BeatCount*BEATLEN +: BEATLEN]; other slices SHALL hold.
REQ-023 BeatCount SHALL increment only on BusReady=1 in WRITEBACK or FETCH, and SHALL wrap from BEATSPERLINE-1 to 0.
REQ-024 On the last writeback beat, the FSM SHALL go to FETCH if the fetch flag is set, else to DONE; on the last fetch beat it SHALL go to DONE.
REQ-025 DONE SHALL assert CacheBusAck for exactly one cycle and then return to IDLE unconditionally; IDLE SHALL never assert it.
REQ-026 Once a burst has started, FlushStage SHALL NOT abort it.
REQ-027 SelBusBeat SHALL be high in WRITEBACK and FETCH.
REQ-028 Latency with zero-wait BusReady SHALL be BEATSPERLINE cycles per phase plus 1 DONE cycle.

Reset
REQ-029 reset=0 SHALL force IDLE, BeatCount=0, FetchBuffer=0, latched address and flags=0, and all outputs low, overriding any burst in progress.

Configuration
REQ-030 With CACHE_BURST_BUSERR_EN defined, an input BusErr (1 bit) and an output CacheBusErr (1 bit) SHALL exist.
REQ-031 BusErr=1 with BusReady=1 SHALL end the burst at that beat, go to DONE, and pulse CacheBusErr together with CacheBusAck; no FetchBuffer write SHALL occur on that beat.
REQ-032 Without CACHE_BURST_BUSERR_EN, neither port SHALL exist and every burst SHALL run to completion.

Structure
REQ-033 The FSM state enum and BUSRW_FETCH/BUSRW_WRITEBACK encodings SHALL be placed in the shared cvw package.
REQ-034 There SHALL be one sub-module, beatcounter: a LOGBWPL-bit enabled counter with synchronous clear and a last-beat flag.

Verification (LINELEN=512, BEATLEN=64, PA_BITS=32)
REQ-035 Fetch 10 at 0x80001040 with BusReady always high -> BusAdr 0x80001040..0x80001078 in 8-byte steps, ack in cycle 9, FetchBuffer equals the 8 supplied beats.
REQ-036 Writeback 01 at 0x1000, ReadDataLine beat k = k -> BusWrite=1, BusWData 0..7, no FetchBuffer change, single ack.
REQ-037 RW=11 -> 8 write beats, then 8 read beats with no gap, one ack at cycle 17.
REQ-038 Fetch with BusReady low on beats 3 and 5 for 2 cycles each -> BeatCount holds, ack at cycle 13, data correct.
REQ-039 RW=10 with FlushStage=1 in IDLE -> no BusReq; reset=0 at beat 4 -> IDLE, BeatCount=0 next cycle, no ack.
REQ-040 With CACHE_BURST_BUSERR_EN, BusErr on fetch beat 2 -> ack and CacheBusErr on the next cycle, beats 2-7 of FetchBuffer unchanged.
